// File: rtl/filter_pkg.sv
// Shared types and constants for the pixel filter pipeline (18-bit raw -> 12-bit DAC).
// Optional grayscale stage is enabled with the GRAYSCALE_EN macro in pixel_filter_pipe.
package filter_pkg;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb18_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    SCR_RGB = 2'b00,
    SCR_GBR = 2'b01,
    SCR_BRG = 2'b10,
    SCR_RRR = 2'b11
  } scramble_e;

  localparam int PIPE_LATENCY = 3;

  // 2x2 Bayer thresholds indexed by {v[0],h[0]}
  localparam logic [1:0] BAYER2 [0:3] = '{2'd0, 2'd2, 2'd3, 2'd1};

  function automatic rgb18_t scramble(input rgb18_t p, input scramble_e sel);
    rgb18_t o;
    o = p;
    case (sel)
      SCR_RGB: o = p;
      SCR_GBR: o = '{r: p.g, g: p.b, b: p.r};
      SCR_BRG: o = '{r: p.b, g: p.r, b: p.g};
      SCR_RRR: o = '{r: p.r, g: p.r, b: p.r};
      default: o = p;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dither_ch.sv
// One colour channel 6->4 bit reduction: truncation or 2x2 ordered dither, saturating at 15.
module dither_ch
  import filter_pkg::*;
(
  input  logic [5:0] i_c,
  input  logic [1:0] i_idx,
  input  logic       i_en,
  output logic [3:0] o_out
);

  logic [1:0] w_thr;
  logic       w_inc;

  assign w_thr = BAYER2[i_idx];
  assign w_inc = i_en && (i_c[1:0] > w_thr);

  always_comb begin
    o_out = i_c[5:2];
    if (w_inc) begin
      o_out = (i_c[5:2] == 4'hF) ? 4'hF : i_c[5:2] + 4'd1;
    end
  end

endmodule

// File: rtl/pixel_filter_pipe.sv
// Three-stage display filter: channel scramble, optional grayscale, 2x2 ordered dither.
// Define GRAYSCALE_EN to honour gray_sw; otherwise stage 2 is a plain register stage.
module pixel_filter_pipe
  import filter_pkg::*;
#(
  parameter int LATENCY = PIPE_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] raw_rgb,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        blank,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  scramble_sel,
  input  logic        gray_sw,
  input  logic        dither_sw,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_o,
  output logic        vsync_o
);

  logic      w_frame_start;
  scramble_e w_sel;
  logic      w_dith;

  scramble_e r_cfg_sel;
  logic      r_cfg_dith;

  rgb18_t r_s1_pix;
  logic   r_s1_h0, r_s1_v0, r_s1_blank, r_s1_hs, r_s1_vs, r_s1_dith;

  rgb18_t w_s2_in;
  rgb18_t r_s2_pix;
  logic   r_s2_h0, r_s2_v0, r_s2_blank, r_s2_hs, r_s2_vs, r_s2_dith;

  rgb12_t r_out;
  logic   r_hs_o, r_vs_o;

  // Pixel (0,0) already sees the new switch settings, so bypass the config regs there.
  assign w_frame_start = (h_count == 11'd0) && (v_count == 10'd0);
  assign w_sel  = w_frame_start ? scramble_e'(scramble_sel) : r_cfg_sel;
  assign w_dith = w_frame_start ? dither_sw : r_cfg_dith;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_sel  <= SCR_RGB;
      r_cfg_dith <= 1'b0;
    end else if (w_frame_start) begin
      r_cfg_sel  <= scramble_e'(scramble_sel);
      r_cfg_dith <= dither_sw;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_pix   <= '0;
      r_s1_h0    <= 1'b0;
      r_s1_v0    <= 1'b0;
      r_s1_blank <= 1'b1;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
      r_s1_dith  <= 1'b0;
    end else begin
      r_s1_pix   <= scramble(rgb18_t'(raw_rgb), w_sel);
      r_s1_h0    <= h_count[0];
      r_s1_v0    <= v_count[0];
      r_s1_blank <= blank;
      r_s1_hs    <= hsync;
      r_s1_vs    <= vsync;
      r_s1_dith  <= w_dith;
    end
  end

`ifdef GRAYSCALE_EN
  logic       r_cfg_gray;
  logic       r_s1_gray;
  logic       w_gray;
  logic [8:0] w_ysum;
  logic [5:0] w_y;

  assign w_gray = w_frame_start ? gray_sw : r_cfg_gray;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_gray <= 1'b0;
      r_s1_gray  <= 1'b0;
    end else begin
      if (w_frame_start) r_cfg_gray <= gray_sw;
      r_s1_gray <= w_gray;
    end
  end

  // Y = (2R + 5G + B) >> 3 built from shifts and adds; max sum 504 fits 9 bits.
  assign w_ysum = {2'b00, r_s1_pix.r, 1'b0}
                + {3'b000, r_s1_pix.g} + {1'b0, r_s1_pix.g, 2'b00}
                + {3'b000, r_s1_pix.b};
  assign w_y    = w_ysum[8:3];
  assign w_s2_in = r_s1_gray ? '{r: w_y, g: w_y, b: w_y} : r_s1_pix;
`else
  logic w_unused_gray;
  assign w_unused_gray = gray_sw;
  assign w_s2_in = r_s1_pix;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_pix   <= '0;
      r_s2_h0    <= 1'b0;
      r_s2_v0    <= 1'b0;
      r_s2_blank <= 1'b1;
      r_s2_hs    <= 1'b1;
      r_s2_vs    <= 1'b1;
      r_s2_dith  <= 1'b0;
    end else begin
      r_s2_pix   <= w_s2_in;
      r_s2_h0    <= r_s1_h0;
      r_s2_v0    <= r_s1_v0;
      r_s2_blank <= r_s1_blank;
      r_s2_hs    <= r_s1_hs;
      r_s2_vs    <= r_s1_vs;
      r_s2_dith  <= r_s1_dith;
    end
  end

  logic [5:0] w_s2_ch [3];
  logic [3:0] w_dith_ch [3];

  assign w_s2_ch[0] = r_s2_pix.r;
  assign w_s2_ch[1] = r_s2_pix.g;
  assign w_s2_ch[2] = r_s2_pix.b;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dith
      dither_ch u_dither_ch (
        .i_c   (w_s2_ch[gi]),
        .i_idx ({r_s2_v0, r_s2_h0}),
        .i_en  (r_s2_dith),
        .o_out (w_dith_ch[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out  <= '0;
      r_hs_o <= 1'b1;
      r_vs_o <= 1'b1;
    end else begin
      r_out  <= r_s2_blank ? '0 : '{r: w_dith_ch[0], g: w_dith_ch[1], b: w_dith_ch[2]};
      r_hs_o <= r_s2_hs;
      r_vs_o <= r_s2_vs;
    end
  end

  assign vga_r   = r_out.r;
  assign vga_g   = r_out.g;
  assign vga_b   = r_out.b;
  assign hsync_o = r_hs_o;
  assign vsync_o = r_vs_o;

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Self-checking bench for pixel_filter_pipe: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model (honours GRAYSCALE_EN like the design).
module tb_pixel_filter_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] raw_rgb = 18'h3FFFF;
  logic [10:0] h_count = 11'd1;
  logic [9:0]  v_count = 10'd1;
  logic        blank = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [1:0]  scramble_sel = 2'b00;
  logic        gray_sw = 1'b0;
  logic        dither_sw = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_o, vsync_o;

  pixel_filter_pipe dut (
    .clk(clk), .reset(reset), .raw_rgb(raw_rgb), .h_count(h_count), .v_count(v_count),
    .blank(blank), .hsync(hsync), .vsync(vsync), .scramble_sel(scramble_sel),
    .gray_sw(gray_sw), .dither_sw(dither_sw), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] RST_OUT = {12'h000, 2'b11};

  int total = 0;
  int bad = 0;
  logic [13:0] expq[$];
  logic [13:0] smp;
  int m_sel, m_gray, m_dith;
  int bayer[4] = '{0, 2, 3, 1};

  // switch values the next step() applies
  logic [1:0] g_sel = 2'b00;
  logic       g_gray = 1'b0;
  logic       g_dith = 1'b0;

  function automatic logic [3:0] reduce(input int c, input int t, input int d);
    int o;
    o = c / 4;
    if (d != 0 && (c % 4) > t) o = o + 1;
    if (o > 15) o = 15;
    return o[3:0];
  endfunction

  // Expected DAC word for the pixel currently on the inputs, given the frame config.
  function automatic logic [13:0] model_pixel(input int sel, input int gr, input int di);
    int r, g, b, cr, cg, cb, y, t;
    logic [3:0] orr, og, ob;
    r = int'(raw_rgb[17:12]);
    g = int'(raw_rgb[11:6]);
    b = int'(raw_rgb[5:0]);
    case (sel)
      1: begin cr = g; cg = b; cb = r; end
      2: begin cr = b; cg = r; cb = g; end
      3: begin cr = r; cg = r; cb = r; end
      default: begin cr = r; cg = g; cb = b; end
    endcase
`ifdef GRAYSCALE_EN
    if (gr != 0) begin
      y = (2 * cr + 5 * cg + cb) / 8;
      cr = y; cg = y; cb = y;
    end
`else
    y = gr;
`endif
    t = bayer[int'(v_count[0]) * 2 + int'(h_count[0])];
    orr = reduce(cr, t, di);
    og  = reduce(cg, t, di);
    ob  = reduce(cb, t, di);
    if (blank) begin orr = 0; og = 0; ob = 0; end
    return {orr, og, ob, hsync, vsync};
  endfunction

  // model: evaluates each captured pixel; the output three edges later must match it
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        expq = '{RST_OUT, RST_OUT};
        m_sel = 0; m_gray = 0; m_dith = 0;
      end else begin
        if (h_count == 0 && v_count == 0) begin
          m_sel = int'(scramble_sel); m_gray = int'(gray_sw); m_dith = int'(dither_sw);
        end
        expq.push_back(model_pixel(m_sel, m_gray, m_dith));
        if (expq.size() > 3) void'(expq.pop_front());
      end
    end
  end

  // per-cycle compare, 2 time units after the falling edge
  initial begin
    logic [13:0] got, expv;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      got = {vga_r, vga_g, vga_b, hsync_o, vsync_o};
      expv = (!reset || expq.size() < 3) ? RST_OUT : expq[0];
      total++;
      if (got !== expv) begin
        bad++;
        $display("FAIL model cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
    end
  end

  task automatic step(input logic [17:0] px, input int h, input int v,
                      input logic bl, input logic hs, input logic vs);
    @(negedge clk);
    smp = {vga_r, vga_g, vga_b, hsync_o, vsync_o};
    raw_rgb = px; h_count = h[10:0]; v_count = v[9:0];
    blank = bl; hsync = hs; vsync = vs;
    scramble_sel = g_sel; gray_sw = g_gray; dither_sw = g_dith;
  endtask

  task automatic px(input logic [17:0] p, input int h, input int v);
    step(p, h, v, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [13:0] expv);
    total++;
    if (smp !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, smp, expv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] gray_exp;
`ifdef GRAYSCALE_EN
    gray_exp = {12'h333, 2'b11};
`else
    gray_exp = {12'hF00, 2'b11};
`endif
    // 1: reset values, then full white three clocks after release
    px(18'h3FFFF, 1, 1);
    px(18'h3FFFF, 1, 1);
    chk("reset_out", {12'h000, 2'b11});
    px(18'h3FFFF, 1, 1); reset = 1'b1;
    px(18'h3FFFF, 2, 1);
    px(18'h3FFFF, 3, 1);
    chk("rel_plus2", {12'h000, 2'b11});
    px(18'h3FFFF, 4, 1);
    chk("rel_white", {12'hFFF, 2'b11});

    // 2: single red pixel with hsync pulse
    px(18'h00000, 3, 2);
    px(18'h00000, 4, 2);
    step(18'h3F000, 5, 2, 1'b0, 1'b0, 1'b1);
    px(18'h00000, 6, 2);
    px(18'h00000, 7, 2);
    chk("lat_before", {12'h000, 2'b11});
    px(18'h00000, 8, 2);
    chk("lat_pixel", {12'hF00, 2'b01});
    px(18'h00000, 9, 2);
    chk("lat_after", {12'h000, 2'b11});

    // 3: scramble 01 latched at (0,0)
    g_sel = 2'b01;
    px(18'h3F000, 0, 0);
    px(18'h00000, 1, 0);
    px(18'h00000, 2, 0);
    px(18'h00000, 3, 0);
    chk("scramble01", {12'h00F, 2'b11});

    // 4: grayscale of pure red
    g_sel = 2'b00; g_gray = 1'b1;
    px(18'h3F000, 0, 0);
    px(18'h00000, 1, 0);
    px(18'h00000, 2, 0);
    px(18'h00000, 3, 0);
    chk("gray_red", gray_exp);

    // 5: dither of level 6 over a 2x2 tile, then saturation at 63
    g_gray = 1'b0; g_dith = 1'b1;
    px(18'h06186, 0, 0);
    px(18'h06186, 1, 0);
    px(18'h06186, 0, 1);
    px(18'h06186, 1, 1);
    chk("dith_h0v0", {12'h222, 2'b11});
    px(18'h3FFFF, 2, 1);
    chk("dith_h1v0", {12'h111, 2'b11});
    px(18'h3FFFF, 3, 1);
    chk("dith_h0v1", {12'h111, 2'b11});
    px(18'h3FFFF, 4, 1);
    chk("dith_h1v1", {12'h222, 2'b11});
    px(18'h00000, 5, 1);
    chk("dith_sat_a", {12'hFFF, 2'b11});
    px(18'h00000, 6, 1);
    chk("dith_sat_b", {12'hFFF, 2'b11});

    // 6: mid-frame gray toggle ignored until next frame; blank forces black
    g_dith = 1'b0;
    px(18'h00000, 0, 0);
    g_gray = 1'b1;
    px(18'h3F000, 5, 100);
    px(18'h00000, 6, 100);
    px(18'h00000, 7, 100);
    px(18'h00000, 8, 100);
    chk("gray_midframe", {12'hF00, 2'b11});
    px(18'h3F000, 0, 0);
    px(18'h00000, 1, 0);
    px(18'h00000, 2, 0);
    px(18'h00000, 3, 0);
    chk("gray_newframe", gray_exp);
    step(18'h3FFFF, 6, 0, 1'b1, 1'b1, 1'b1);
    px(18'h00000, 7, 0);
    px(18'h00000, 8, 0);
    px(18'h00000, 9, 0);
    chk("blank_black", {12'h000, 2'b11});

    // randomized traffic with occasional mid-frame resets
    for (int i = 0; i < 3000; i++) begin
      g_sel  = 2'($urandom_range(0, 3));
      g_gray = 1'($urandom_range(0, 1));
      g_dith = 1'($urandom_range(0, 1));
      step(18'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      else if (!reset && $urandom_range(0, 1) == 0) reset = 1'b1;
    end
    reset = 1'b1;
    repeat (5) px(18'h00000, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
